box_area_scheduler: RTL and testbench
=====================================

# box_area_scheduler

Round-robin scheduler that shares one box-area datapath (|C−A| × |D−B|, A/B 4-bit, C/D 3-bit, 8-bit product) between two requesters. It latches the winning requester's operands, sequences the computation, and presents a registered result on a valid/ready port. It also keeps a saturating running total of delivered areas. The block sits between the SPU's two operand sources and the shared area unit; the area unit stays combinational and is instantiated inside this block.

## Interface
Parameters:
- ACC_W, default 12: width of the running-total accumulator.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1; hold high with operands stable until the matching ack.
- a0, b0 / a1, b1  in  4  per-requester A, B operands.
- c0, d0 / c1, d1  in  3  per-requester C, D operands.
- ack0 / ack1  out  1  one-cycle pulse: operands accepted.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  requester that owns the result.
- res_area  out  8  area; [7:4] is the high nibble, [3:0] is the low nibble.
- acc_clr  in  1  clear the running total.
- acc_total  out  ACC_W  saturating sum of delivered areas.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- **IDLE:**
  - If req0 or req1 is high, grant one requester.
  - The latched grant pointer prio (reset 0) chooses on a tie: prio=0 grants requester 0, prio=1 grants requester 1. A lone request is always granted.
  - On grant: latch that requester's a/b/c/d and id, pulse ack for the next cycle, set prio to the non-granted id, go to COMPUTE.
- **COMPUTE:**
  - C and D are zero-extended to 4 bits.
  - dX = |C−A| and dY = |D−B| are computed as 4-bit magnitudes.
  - area = dX × dY is computed as an 8-bit value with no truncation (max 15×15 = 225).
  - Register area into res_area. Go to DONE.
- **DONE:**
  - res_valid is high; res_area and res_id are stable.
  - On res_valid && res_ready: acc_total += res_area, saturating at 2^ACC_W−1. Then go to IDLE.
- req is sampled only in IDLE. A req held high after its ack is treated as a new request.
- acc_clr:
  - When asserted, acc_total becomes 0 at the next edge, in any state.
  - If it coincides with a result handshake, clear wins: the delivered area is not added.
- Other states ignore acc_clr only in the sense that the FSM is unaffected.

## Timing
- Reset values:
  - State = IDLE, prio = 0.
  - ack0 = ack1 = 0, res_valid = 0, res_id = 0, res_area = 0, acc_total = 0, busy = 0.
  - Latched operands = 0.
- Latency, with req seen in IDLE at cycle N:
  - ack in cycle N+1 (state COMPUTE).
  - res_valid in cycle N+2 at the earliest.
- Handshake completes at the first edge where res_valid && res_ready. The FSM is back in IDLE the following cycle.
- Throughput: one result per 3 cycles with res_ready held high.
- Back-pressure: DONE holds indefinitely. Requests wait; no request is dropped or acked while the FSM is not in IDLE.
- res_ready while res_valid is low has no effect.
- Reset asserted mid-operation:
  - Any in-flight result is discarded with no ack re-issue.
  - All outputs return to their reset values on the next edge.

## Test plan
- **Single request:** req0 with a0=2, b0=3, c0=7, d0=6, res_ready=1. Required: ack0 at N+1, res_valid at N+2, res_area=0x0F, res_id=0, acc_total=15.
- **Max and zero area:**
  - a1=15, b1=15, c1=0, d1=0 gives res_area=0xE1 (225).
  - a1=5, c1=5 (any b/d) gives res_area=0x00.
- **Contention:**
  - req0 and req1 high together from reset: grant order is 0, 1, 0, 1 across four transactions, with res_id matching.
  - A lone req1 when prio=0 is granted immediately.
- **Back-pressure:** res_ready low for 5 cycles in DONE. Required: res_valid, res_area and res_id hold; no ack is issued to a pending req1; the handshake completes on the first cycle res_ready rises.
- **Accumulator:**
  - 19 results of 225: acc_total is 4050 after 18 and saturates at 4095 on the 19th.
  - acc_clr on the same edge as a handshake leaves acc_total=0.
- **Reset mid-operation:** rst asserted in COMPUTE. Required: next cycle is IDLE, res_valid=0, acc_total=0, and prio=0 (a simultaneous req0/req1 then grants requester 0).

Source files
------------

// File: rtl/box_area_scheduler.sv
// Round-robin front end for a shared combinational box-area unit (|C-A| x |D-B|).
// Grants one of two requesters, latches its operands, and delivers a registered result.

module box_area_unit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic [2:0] c_i,
   input  logic [2:0] d_i,
   output logic [7:0] area_o
);
   logic [3:0] cx_s;
   logic [3:0] dy_ext_s;
   logic [3:0] dx_s;
   logic [3:0] dy_s;

   always_comb begin
      cx_s     = {1'b0, c_i};
      dy_ext_s = {1'b0, d_i};
      dx_s     = (cx_s >= a_i) ? (cx_s - a_i) : (a_i - cx_s);
      dy_s     = (dy_ext_s >= b_i) ? (dy_ext_s - b_i) : (b_i - dy_ext_s);
      area_o   = {4'd0, dx_s} * {4'd0, dy_s};
   end
endmodule

module box_area_scheduler #(
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [3:0]       a0,
   input  logic [3:0]       b0,
   input  logic [2:0]       c0,
   input  logic [2:0]       d0,
   input  logic [3:0]       a1,
   input  logic [3:0]       b1,
   input  logic [2:0]       c1,
   input  logic [2:0]       d1,
   output logic             ack0,
   output logic             ack1,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [7:0]       res_area,
   input  logic             acc_clr,
   output logic [ACC_W-1:0] acc_total,
   output logic             busy
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [3:0]       op_a_q, op_a_d;
   logic [3:0]       op_b_q, op_b_d;
   logic [2:0]       op_c_q, op_c_d;
   logic [2:0]       op_d_q, op_d_d;
   logic             id_q, id_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             res_valid_q, res_valid_d;
   logic             res_id_q, res_id_d;
   logic [7:0]       res_area_q, res_area_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             busy_q, busy_d;

   logic             grant_s;
   logic [7:0]       area_s;
   logic [ACC_W:0]   sum_s;
   logic [ACC_W-1:0] acc_sat_s;

   box_area_unit u_area (
      .a_i    (op_a_q),
      .b_i    (op_b_q),
      .c_i    (op_c_q),
      .d_i    (op_d_q),
      .area_o (area_s)
   );

   // One extra bit catches overflow so the total clamps at all-ones.
   always_comb begin
      sum_s     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, res_area_q};
      acc_sat_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
      grant_s   = (req0 && req1) ? prio_q : req1;
   end

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_c_d      = op_c_q;
      op_d_d      = op_d_q;
      id_d        = id_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_area_d  = res_area_q;
      acc_d       = acc_q;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_COMPUTE;
               id_d    = grant_s;
               prio_d  = ~grant_s;
               ack0_d  = ~grant_s;
               ack1_d  = grant_s;
               if (grant_s) begin
                  op_a_d = a1;
                  op_b_d = b1;
                  op_c_d = c1;
                  op_d_d = d1;
               end else begin
                  op_a_d = a0;
                  op_b_d = b0;
                  op_c_d = c0;
                  op_d_d = d0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COMPUTE: begin
            res_area_d  = area_s;
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               acc_d       = acc_sat_s;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
         end
      endcase

      // Clear beats a coinciding handshake: the delivered area is dropped.
      if (acc_clr) begin
         acc_d = {ACC_W{1'b0}};
      end else begin
         acc_d = acc_d;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prio_q      <= 1'b0;
         op_a_q      <= 4'd0;
         op_b_q      <= 4'd0;
         op_c_q      <= 3'd0;
         op_d_q      <= 3'd0;
         id_q        <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_area_q  <= 8'd0;
         acc_q       <= {ACC_W{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_c_q      <= op_c_d;
         op_d_q      <= op_d_d;
         id_q        <= id_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_area_q  <= res_area_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_area  = res_area_q;
   assign acc_total = acc_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_box_area_scheduler.sv
// Scoreboard bench for box_area_scheduler: a cycle-level reference model predicts grants,
// results and the running total; a negedge monitor compares the DUT against it.

module tb_box_area_scheduler;
   localparam int ACC_W   = 12;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic             clk;
   logic             rst;
   logic             req0, req1;
   logic [3:0]       a0, b0, a1, b1;
   logic [2:0]       c0, d0, c1, d1;
   logic             ack0, ack1;
   logic             res_valid;
   logic             res_ready;
   logic             res_id;
   logic [7:0]       res_area;
   logic             acc_clr;
   logic [ACC_W-1:0] acc_total;
   logic             busy;

   box_area_scheduler #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .a0        (a0),
      .b0        (b0),
      .c0        (c0),
      .d0        (d0),
      .a1        (a1),
      .b1        (b1),
      .c1        (c1),
      .d1        (d1),
      .ack0      (ack0),
      .ack1      (ack1),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_area  (res_area),
      .acc_clr   (acc_clr),
      .acc_total (acc_total),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int area;
   } exp_t;

   exp_t sb_q[$];
   int   grant_log[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_hs     = 0;
   int   last_area = -1;

   // Reference model: 0 = waiting for requests, 1 = computing, 2 = holding a result.
   int m_state = 0;
   int m_prio  = 0;
   int m_acc   = 0;
   int m_ack0  = 0;
   int m_ack1  = 0;
   int m_init  = 0;
   int m_rst_seen = 0;

   function automatic int ref_area(input int a, input int b, input int c, input int d);
      int dx, dy;
      dx = (c > a) ? c - a : a - c;
      dy = (d > b) ? d - b : b - d;
      return dx * dy;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT with the model, then advance the model across the coming edge.
   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (m_init != 0) begin
         check("res_valid", int'(res_valid), (m_state == 2) ? 1 : 0);
         check("busy", int'(busy), (m_state != 0) ? 1 : 0);
         check("ack0", int'(ack0), m_ack0);
         check("ack1", int'(ack1), m_ack1);
         check("acc_total", int'(acc_total), m_acc);
         if (m_rst_seen != 0) begin
            check("rst_res_id", int'(res_id), 0);
            check("rst_res_area", int'(res_area), 0);
         end
         if (m_state == 2) begin
            if (sb_q.size() > 0) begin
               check("res_id", int'(res_id), sb_q[0].id);
               check("res_area", int'(res_area), sb_q[0].area);
            end else begin
               check("sb_underflow", 1, 0);
            end
         end
         if (ack0) grant_log.push_back(0);
         if (ack1) grant_log.push_back(1);
      end

      if (rst) begin
         m_state = 0;
         m_prio  = 0;
         m_acc   = 0;
         m_ack0  = 0;
         m_ack1  = 0;
         sb_q.delete();
         m_init  = 1;
         m_rst_seen = 1;
      end else if (m_init != 0) begin
         m_rst_seen = 0;
         m_ack0 = 0;
         m_ack1 = 0;
         case (m_state)
            0: begin
               if (req0 || req1) begin
                  g = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
                  e.id   = g;
                  e.area = (g == 1) ? ref_area(a1, b1, c1, d1) : ref_area(a0, b0, c0, d0);
                  sb_q.push_back(e);
                  if (g == 1) m_ack1 = 1;
                  else m_ack0 = 1;
                  m_prio  = 1 - g;
                  m_state = 1;
               end
            end
            1: m_state = 2;
            2: begin
               if (res_ready) begin
                  last_area = int'(res_area);
                  if (sb_q.size() > 0) begin
                     m_acc = m_acc + sb_q[0].area;
                     if (m_acc > ACC_MAX) m_acc = ACC_MAX;
                     void'(sb_q.pop_front());
                  end
                  n_hs++;
                  m_state = 0;
               end
            end
            default: m_state = 0;
         endcase
         if (acc_clr) m_acc = 0;
      end
   end

   task automatic set_ops(input int id, input int a, input int b, input int c, input int d);
      if (id == 1) begin
         a1 = 4'(a); b1 = 4'(b); c1 = 3'(c); d1 = 3'(d);
      end else begin
         a0 = 4'(a); b0 = 4'(b); c0 = 3'(c); d0 = 3'(d);
      end
   endtask

   task automatic wait_ack(input int id);
      int k;
      for (k = 0; k < 20; k++) begin
         tick();
         if ((id == 0 && ack0) || (id == 1 && ack1)) break;
      end
      check("ack_timeout", (k < 20) ? 1 : 0, 1);
   endtask

   task automatic wait_hs(input int target);
      int k;
      for (k = 0; k < 60 && n_hs < target; k++) tick();
      check("handshake_timeout", (n_hs >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_valid();
      int k;
      for (k = 0; k < 20 && !res_valid; k++) tick();
      check("valid_timeout", int'(res_valid), 1);
   endtask

   task automatic do_one(input int id, input int a, input int b, input int c, input int d);
      int target;
      target = n_hs + 1;
      set_ops(id, a, b, c, d);
      if (id == 1) req1 = 1'b1;
      else req0 = 1'b1;
      wait_ack(id);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_hs(target);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int target;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0; acc_clr = 1'b0;
      set_ops(0, 0, 0, 0, 0);
      set_ops(1, 0, 0, 0, 0);
      repeat (3) tick();
      rst = 1'b0;

      // Single request: ack at N+1, result at N+2, total 15 after handshake.
      res_ready = 1'b1;
      set_ops(0, 2, 3, 7, 6);
      req0 = 1'b1;
      tick();
      check("single_ack0", int'(ack0), 1);
      req0 = 1'b0;
      tick();
      check("single_valid", int'(res_valid), 1);
      check("single_area", int'(res_area), 15);
      check("single_id", int'(res_id), 0);
      tick();
      check("single_acc", int'(acc_total), 15);

      // Maximum and zero area.
      do_one(1, 15, 15, 0, 0);
      check("max_area", last_area, 225);
      do_one(1, 5, $urandom_range(15), 5, $urandom_range(7));
      check("zero_area", last_area, 0);

      // Contention from reset: strict alternation starting with requester 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant_log.delete();
      set_ops(0, $urandom_range(15), $urandom_range(15), $urandom_range(7), $urandom_range(7));
      set_ops(1, $urandom_range(15), $urandom_range(15), $urandom_range(7), $urandom_range(7));
      target = n_hs + 4;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int k = 0; k < 40 && grant_log.size() < 4; k++) tick();
      req0 = 1'b0;
      req1 = 1'b0;
      check("contention_grants", grant_log.size(), 4);
      if (grant_log.size() >= 4) begin
         check("grant_order0", grant_log[0], 0);
         check("grant_order1", grant_log[1], 1);
         check("grant_order2", grant_log[2], 0);
         check("grant_order3", grant_log[3], 1);
      end
      wait_hs(target);

      // Lone req1 while prio points at requester 0.
      set_ops(1, 12, 1, 4, 6);
      target = n_hs + 1;
      req1 = 1'b1;
      tick();
      check("lone_req1_ack", int'(ack1), 1);
      req1 = 1'b0;
      wait_hs(target);

      // Back-pressure: result holds for 5 cycles, pending req1 is not acked.
      res_ready = 1'b0;
      set_ops(0, 9, 1, 3, 6);
      req0 = 1'b1;
      wait_ack(0);
      req0 = 1'b0;
      set_ops(1, 1, 2, 7, 7);
      req1 = 1'b1;
      wait_valid();
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_valid_hold", int'(res_valid), 1);
         check("bp_area_hold", int'(res_area), 30);
         check("bp_id_hold", int'(res_id), 0);
         check("bp_no_ack1", int'(ack1), 0);
      end
      target = n_hs + 2;
      res_ready = 1'b1;
      tick();
      check("bp_release_valid", int'(res_valid), 0);
      check("bp_release_busy", int'(busy), 0);
      wait_ack(1);
      req1 = 1'b0;
      wait_hs(target);

      // Saturating accumulator.
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      check("acc_cleared", int'(acc_total), 0);
      for (int i = 0; i < 19; i++) begin
         do_one(i % 2, 15, 15, 0, 0);
         if (i == 17) check("acc_after_18", int'(acc_total), 4050);
         if (i == 18) check("acc_saturated", int'(acc_total), 4095);
      end

      // Clear coinciding with a handshake wins.
      res_ready = 1'b0;
      set_ops(0, 3, 2, 6, 7);
      req0 = 1'b1;
      wait_ack(0);
      req0 = 1'b0;
      wait_valid();
      acc_clr = 1'b1;
      res_ready = 1'b1;
      tick();
      acc_clr = 1'b0;
      check("clr_vs_handshake_acc", int'(acc_total), 0);
      check("clr_vs_handshake_valid", int'(res_valid), 0);

      // Reset during COMPUTE after a grant to requester 0 (prio now 1).
      do_one(1, 8, 8, 2, 1);
      set_ops(0, 14, 0, 1, 7);
      req0 = 1'b1;
      wait_ack(0);
      req0 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", int'(res_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_acc", int'(acc_total), 0);
      target = n_hs + 1;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      check("midrst_prio_ack0", int'(ack0), 1);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_hs(target);

      // Randomised traffic with random back-pressure and occasional clears.
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (ack0) req0 = 1'b0;
         else if (!req0 && ($urandom_range(2) == 0)) begin
            set_ops(0, $urandom_range(15), $urandom_range(15), $urandom_range(7), $urandom_range(7));
            req0 = 1'b1;
         end
         if (ack1) req1 = 1'b0;
         else if (!req1 && ($urandom_range(2) == 0)) begin
            set_ops(1, $urandom_range(15), $urandom_range(15), $urandom_range(7), $urandom_range(7));
            req1 = 1'b1;
         end
         res_ready = ($urandom_range(3) != 0);
         acc_clr   = ($urandom_range(31) == 0);
         tick();
      end
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      acc_clr   = 1'b0;
      res_ready = 1'b1;
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      for (int k = 0; k < 30 && (busy || req0 || req1); k++) tick();
      repeat (2) tick();
      check("drain_busy", int'(busy), 0);
      check("drain_scoreboard", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
